// File: rtl/zx_video_pkg.sv
// Shared ZX Spectrum display constants, fetch FSM state type and screen address helpers.
package zx_video_pkg;

  localparam int unsigned SCREEN_W       = 256;
  localparam int unsigned SCREEN_H       = 192;
  localparam int unsigned BYTES_PER_LINE = SCREEN_W / 8;
  localparam logic [15:0] ATTR_OFFSET    = 16'h1800;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } fetch_state_e;

  // Bitmap rows are interleaved: thirds, then pixel row within char, then char row.
  function automatic logic [15:0] bitmap_addr(input logic [15:0] base, input logic [7:0] y,
                                              input logic [4:0] col);
    return base + {3'b000, y[7:6], y[2:0], y[5:3], col};
  endfunction

  function automatic logic [15:0] attr_addr(input logic [15:0] base, input logic [7:0] y,
                                            input logic [4:0] col);
    return base + ATTR_OFFSET + {6'b000000, y[7:3], col};
  endfunction

endpackage

// File: rtl/zx_line_buffer.sv
// Two banks of one display line each: slots 0..31 bitmap, 32..63 attributes.
module zx_line_buffer
  import zx_video_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_wr_en,
  input  logic       i_wr_bank,
  input  logic [5:0] i_wr_idx,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd_bank,
  input  logic [4:0] i_rd_col,
  output logic [7:0] o_bitmap,
  output logic [7:0] o_attr
);

  localparam int unsigned Slots = 2 * BYTES_PER_LINE;

  logic [7:0] r_mem [2][Slots];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_bank][i_wr_idx] <= i_wr_data;
    end
  end

  assign o_bitmap = r_mem[i_rd_bank][{1'b0, i_rd_col}];
  assign o_attr   = r_mem[i_rd_bank][{1'b1, i_rd_col}];

endmodule

// File: rtl/zx_screen_fetch.sv
// Fetches one ZX Spectrum display line from RAM into a double-buffered line store and
// decodes per-pixel colour indices from the front bank.
module zx_screen_fetch
  import zx_video_pkg::*;
#(
  parameter logic [15:0] SCREEN_BASE = 16'h0000,
  parameter int unsigned FLASH_BIT   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_line_start,
  input  logic [7:0]  i_line_y,
  input  logic        i_frame_start,
  output logic [15:0] o_mem_addr,
  input  logic [7:0]  i_mem_dout,
  output logic        o_fetch_busy,
  output logic        o_fetch_done,
  input  logic        i_pix_en,
  input  logic [7:0]  i_pix_x,
  output logic [3:0]  o_pix_colour,
  output logic        o_pix_valid
);

  fetch_state_e r_state, w_state_next;

  logic [6:0]  r_idx;
  logic [7:0]  r_y;
  logic [15:0] r_addr;
  logic        r_busy;
  logic        r_done;
  logic        r_front;
  logic        r_have_line;
  logic [4:0]  r_frame;
  logic [3:0]  r_pix_colour;
  logic        r_pix_valid;

  logic        w_start;
  logic        w_issue;
  logic        w_capture;
  logic        w_swap;
  logic [5:0]  w_wr_idx;
  logic [7:0]  w_bitmap;
  logic [7:0]  w_attr;
  logic        w_bit;
  logic        w_flash;
  logic        w_lookup;
  logic [2:0]  w_ink;
  logic [2:0]  w_paper;
  logic [3:0]  w_colour;

  assign w_start = i_line_start && ({24'd0, i_line_y} < SCREEN_H);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_next = StFetch;
      StFetch: if (r_idx == 7'd64) w_state_next = StDrain;
      StDrain: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // r_idx runs 0..64: 0..63 issue addresses, the final step only captures byte 63.
  always_comb begin
    w_issue   = 1'b0;
    w_capture = 1'b0;
    w_swap    = 1'b0;
    unique case (r_state)
      StFetch: begin
        w_issue   = !r_idx[6];
        w_capture = (r_idx != 7'd0);
      end
      StDrain: w_swap = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx       <= '0;
      r_y         <= '0;
      r_addr      <= SCREEN_BASE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_front     <= 1'b0;
      r_have_line <= 1'b0;
      r_frame     <= '0;
    end else begin
      r_done <= w_swap;
      if (i_frame_start) begin
        r_frame <= r_frame + 5'd1;
      end
      if ((r_state == StIdle) && w_start) begin
        r_idx <= '0;
        r_y   <= i_line_y;
      end
      if (w_issue) begin
        r_addr <= r_idx[5] ? attr_addr(SCREEN_BASE, r_y, r_idx[4:0])
                           : bitmap_addr(SCREEN_BASE, r_y, r_idx[4:0]);
        r_idx  <= r_idx + 7'd1;
        r_busy <= 1'b1;
      end
      if (w_swap) begin
        r_busy      <= 1'b0;
        r_front     <= ~r_front;
        r_have_line <= 1'b1;
      end
    end
  end

  // Data on the bus belongs to the previously issued index.
  assign w_wr_idx = r_idx[5:0] - 6'd1;

  zx_line_buffer u_line_buffer (
    .i_clk     (i_clk),
    .i_wr_en   (w_capture),
    .i_wr_bank (~r_front),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (i_mem_dout),
    .i_rd_bank (r_front),
    .i_rd_col  (i_pix_x[7:3]),
    .o_bitmap  (w_bitmap),
    .o_attr    (w_attr)
  );

  assign w_bit    = w_bitmap[3'd7 - i_pix_x[2:0]];
  assign w_flash  = r_frame[FLASH_BIT];
  assign w_ink    = (w_attr[7] && w_flash) ? w_attr[5:3] : w_attr[2:0];
  assign w_paper  = (w_attr[7] && w_flash) ? w_attr[2:0] : w_attr[5:3];
  assign w_colour = {w_attr[6], w_bit ? w_ink : w_paper};
  assign w_lookup = i_pix_en && r_have_line;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix_valid  <= 1'b0;
      r_pix_colour <= 4'h0;
    end else begin
      r_pix_valid  <= w_lookup;
      r_pix_colour <= w_lookup ? w_colour : 4'h0;
    end
  end

  assign o_mem_addr   = r_addr;
  assign o_fetch_busy = r_busy;
  assign o_fetch_done = r_done;
  assign o_pix_colour = r_pix_colour;
  assign o_pix_valid  = r_pix_valid;

endmodule

// File: tb/tb_zx_screen_fetch.sv
// Directed bench for zx_screen_fetch: address sequencing, fetch timing, pixel decode,
// flash, ignored strobes, mid-fetch reset and buffer swap under continuous lookups.
module tb_zx_screen_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [7:0]  line_y;
  logic        frame_start;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        fetch_busy;
  logic        fetch_done;
  logic        pix_en;
  logic [7:0]  pix_x;
  logic [3:0]  pix_colour;
  logic        pix_valid;

  logic [7:0]  ram [0:65535];
  int          n_checks = 0;
  int          n_err    = 0;

  always #5 clk = ~clk;

  assign mem_dout = ram[mem_addr];

  zx_screen_fetch #(
    .SCREEN_BASE (16'h0000),
    .FLASH_BIT   (4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_line_start  (line_start),
    .i_line_y      (line_y),
    .i_frame_start (frame_start),
    .o_mem_addr    (mem_addr),
    .i_mem_dout    (mem_dout),
    .o_fetch_busy  (fetch_busy),
    .o_fetch_done  (fetch_done),
    .i_pix_en      (pix_en),
    .i_pix_x       (pix_x),
    .o_pix_colour  (pix_colour),
    .o_pix_valid   (pix_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_addr(input logic [7:0] y, input int i);
    logic [4:0] c;
    c = i[4:0];
    if (i < 32) return {3'b000, y[7:6], y[2:0], y[5:3], c};
    return 16'h1800 + {6'b000000, y[7:3], c};
  endfunction

  // Strobe a line at edge 0 and check address/busy/done on every edge 1..67.
  task automatic run_fetch(input logic [7:0] y, input string tag,
                           output logic [15:0] a0, output logic [15:0] a32);
    line_start = 1'b1;
    line_y     = y;
    tick();
    line_start = 1'b0;
    a0  = 'x;
    a32 = 'x;
    for (int k = 1; k <= 67; k++) begin
      tick();
      if (k <= 64) check({tag, "_addr"}, mem_addr, exp_addr(y, k - 1));
      if (k == 1) a0 = mem_addr;
      if (k == 33) a32 = mem_addr;
      check({tag, "_busy"}, 16'(fetch_busy), 16'((k <= 65) ? 1 : 0));
      check({tag, "_done"}, 16'(fetch_done), 16'((k == 66) ? 1 : 0));
    end
  endtask

  task automatic lookup(input logic [7:0] x, input logic [3:0] exp_c, input string tag);
    pix_en = 1'b1;
    pix_x  = x;
    tick();
    pix_en = 1'b0;
    check({tag, "_valid"}, 16'(pix_valid), 16'h1);
    check(tag, 16'(pix_colour), 16'(exp_c));
  endtask

  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] a0, a32;
    int          n_bad, n_done, done_k;

    rst_n       = 1'b0;
    line_start  = 1'b0;
    line_y      = 8'd0;
    frame_start = 1'b0;
    pix_en      = 1'b0;
    pix_x       = 8'd0;
    for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
    ram[16'h0000] = 8'h80;  ram[16'h1800] = 8'h47;
    ram[16'h0001] = 8'h0F;  ram[16'h1801] = 8'h38;
    ram[16'h0100] = 8'h7F;
    ram[16'h0902] = 8'hFF;  ram[16'h1902] = 8'h87;

    repeat (2) tick();
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_busy", 16'(fetch_busy), 16'h0);
    check("rst_done", 16'(fetch_done), 16'h0);
    check("rst_valid", 16'(pix_valid), 16'h0);
    check("rst_colour", 16'(pix_colour), 16'h0);
    rst_n = 1'b1;
    tick();

    pix_en = 1'b1;
    pix_x  = 8'd0;
    tick();
    pix_en = 1'b0;
    check("noline_valid", 16'(pix_valid), 16'h0);
    check("noline_colour", 16'(pix_colour), 16'h0);

    run_fetch(8'd0, "y0", a0, a32);
    check("y0_first_bmp", a0, 16'h0000);
    check("y0_first_attr", a32, 16'h1800);

    lookup(8'd0, 4'hF, "px0");
    lookup(8'd1, 4'h8, "px1");
    lookup(8'd8, 4'h7, "px8");
    lookup(8'd11, 4'h7, "px11");
    lookup(8'd12, 4'h0, "px12");
    lookup(8'd15, 4'h0, "px15");
    tick();
    check("idle_valid", 16'(pix_valid), 16'h0);
    check("idle_colour", 16'(pix_colour), 16'h0);

    run_fetch(8'd65, "y65", a0, a32);
    check("y65_first_bmp", a0, 16'h0900);
    check("y65_first_attr", a32, 16'h1900);

    lookup(8'd16, 4'h7, "flash_f0");
    frame_pulses(15);
    lookup(8'd16, 4'h7, "flash_f15");
    frame_pulses(1);
    lookup(8'd16, 4'h0, "flash_f16");
    frame_pulses(16);
    lookup(8'd16, 4'h7, "flash_f32");

    // Off-screen line must cause no activity at all.
    line_start = 1'b1;
    line_y     = 8'd192;
    tick();
    line_start = 1'b0;
    n_bad = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (mem_addr !== 16'h191F || fetch_busy !== 1'b0 || fetch_done !== 1'b0) n_bad++;
    end
    check("y192_activity", 16'(n_bad), 16'h0);

    // Second strobe while busy is ignored.
    line_start = 1'b1;
    line_y     = 8'd0;
    tick();
    line_start = 1'b0;
    n_done = 0;
    done_k = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      line_start = 1'b0;
      if (k == 9) begin
        line_start = 1'b1;
        line_y     = 8'd8;
      end
      if (k == 64) check("dbl_last_addr", mem_addr, 16'h181F);
      if (fetch_done === 1'b1) begin
        n_done++;
        done_k = k;
      end
    end
    check("dbl_done_count", 16'(n_done), 16'h1);
    check("dbl_done_edge", 16'(done_k), 16'd66);

    // Reset in the middle of a fetch.
    pix_en = 1'b1;
    pix_x  = 8'd0;
    line_start = 1'b1;
    line_y     = 8'd0;
    tick();
    line_start = 1'b0;
    repeat (30) tick();
    check("pre_rst_valid", 16'(pix_valid), 16'h1);
    check("pre_rst_busy", 16'(fetch_busy), 16'h1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_addr", mem_addr, 16'h0000);
    check("mid_rst_busy", 16'(fetch_busy), 16'h0);
    check("mid_rst_done", 16'(fetch_done), 16'h0);
    check("mid_rst_valid", 16'(pix_valid), 16'h0);
    check("mid_rst_colour", 16'(pix_colour), 16'h0);
    rst_n = 1'b1;
    n_bad = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (pix_valid !== 1'b0 || pix_colour !== 4'h0 || fetch_done !== 1'b0 ||
          fetch_busy !== 1'b0) n_bad++;
    end
    check("post_rst_quiet", 16'(n_bad), 16'h0);

    // Swap under continuous lookups: line 0 through the swap edge, line 1 afterwards.
    run_fetch(8'd0, "ov_y0", a0, a32);
    check("ov_y0_first_bmp", a0, 16'h0000);
    line_start = 1'b1;
    line_y     = 8'd1;
    tick();
    line_start = 1'b0;
    check("ov_k0_colour", 16'(pix_colour), 16'hF);
    for (int k = 1; k <= 70; k++) begin
      tick();
      check("ov_valid", 16'(pix_valid), 16'h1);
      check("ov_colour", 16'(pix_colour), (k <= 66) ? 16'hF : 16'h8);
      if (k == 66) check("ov_done", 16'(fetch_done), 16'h1);
    end
    pix_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/zx_screen_fetch.md
# zx_screen_fetch

Read-side client of the shared 48K system RAM: fetches one ZX Spectrum display line from the RAM's video read port and serves colour indices to the video timing/output stage. For each active line it reads 32 bitmap bytes and 32 attribute bytes into a double-buffered line store. It then decodes per-pixel ink, paper, bright and flash. The RAM read port has fixed 1-cycle latency, with no handshake on the RAM side.

## Interface
Parameters:
- SCREEN_BASE, 16'h0000, RAM offset of bitmap byte (x=0,y=0)
- FLASH_BIT, 4, frame-counter bit used as flash phase (toggles every 16 frames)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- line_start  in  1  one-cycle strobe: fetch line line_y
- line_y  in  8  display line, valid 0..191, sampled with line_start
- frame_start  in  1  one-cycle strobe, once per frame
- mem_addr  out  16  registered RAM read address
- mem_dout  in  8  RAM read data, valid one cycle after mem_addr
- fetch_busy  out  1  high while a fetch is in progress
- fetch_done  out  1  one-cycle pulse when a line is stored and swapped in
- pix_en  in  1  pixel lookup request
- pix_x  in  8  pixel column 0..255, sampled with pix_en
- pix_colour  out  4  {bright, G, R, B}
- pix_valid  out  1  pix_colour valid

## Operation
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE→FETCH on line_start with line_y<192.
  - line_start with line_y≥192: ignored, no fetch_done.
  - line_start while not IDLE: ignored.
- FETCH issues 64 addresses, index i=0..63:
  - i<32, bitmap: SCREEN_BASE + {y[7:6], y[2:0], y[5:3], i[4:0]}.
  - i≥32, attribute: SCREEN_BASE + 16'h1800 + {y[7:3], i[4:0]}.
  - All sums are 16-bit, wrapping modulo 2^16.
- After index 63: FETCH→DRAIN for one cycle to capture the last byte, then DRAIN→IDLE.
- Capture: mem_dout is written to the back buffer slot (i−1) in the cycle after each address.
- Swap on DRAIN→IDLE:
  - The back buffer becomes the front buffer.
  - fetch_done pulses.
  - A have_line flag is set.
- Pixel decode, from the front buffer only:
  - b = bitmap[pix_x[7:3]][7−pix_x[2:0]]; a = attr[pix_x[7:3]].
  - ink = a[2:0], paper = a[5:3].
  - If a[7] and flash_phase: swap ink and paper.
  - pix_colour = {a[6], b ? ink : paper}.
- pix_valid = pix_en & have_line, registered.
  - When pix_valid is 0, pix_colour is 4'h0.
- Flash: 5-bit frame counter, +1 on each frame_start, wraps 31→0. flash_phase = counter[FLASH_BIT].

## Timing
- Reset values, all async:
  - State IDLE; mem_addr = SCREEN_BASE; fetch_busy 0; fetch_done 0.
  - pix_colour 0; pix_valid 0; frame counter 0; front select 0; have_line 0.
  - Buffer contents are not reset.
- line_start sampled at edge 0:
  - mem_addr = index 0 after edge 1, index 63 after edge 64.
  - fetch_busy is high from edge 1 through edge 65.
  - Last byte captured at edge 65.
  - fetch_done is high for one cycle after edge 66, coincident with the swap.
  - Total latency from line_start to fetch_done: 66 cycles.
- In IDLE, mem_addr holds its last value.
- Pixel lookup latency: pix_en/pix_x at edge N → pix_colour/pix_valid after edge N+1.
- Fully pipelined: one lookup per cycle.
- A lookup sampled at the swap edge uses the pre-swap front buffer.
- frame_start and line_start together: both take effect independently.
- frame_start mid-line: the flash phase change is visible on the next lookup.
- rst_n low mid-fetch:
  - Fetch aborts and all state returns to reset values.
  - pix_valid stays 0 until the next completed fetch.

## Structure
- Package zx_video_pkg holds:
  - Constants: SCREEN_W=256, SCREEN_H=192, BYTES_PER_LINE=32, ATTR_OFFSET=16'h1800.
  - The FSM state enum.
  - A bitmap-address helper function.
- Sub-module zx_line_buffer: two banks of 64 bytes with write port (bank, index, data) and front-bank read of bitmap and attribute by column.
  - The swap signal is owned by zx_screen_fetch.

## Test plan
- Reset, then line_start with y=0:
  - mem_addr sequence 0x0000..0x001F, then 0x1800..0x181F.
  - fetch_done exactly 66 cycles after line_start; fetch_busy high for 65 cycles.
- line_y=65 (0b01000001), SCREEN_BASE=0: first address 0x0900, first attribute address 0x1900.
- RAM model with bitmap byte 0x80 and attr 0x47 at column 0:
  - pix_x=0 → pix_colour 4'hF (bright white ink).
  - pix_x=1 → 4'h8 (bright black paper).
  - Both one cycle after pix_en.
- Attr 0x87, bitmap 0xFF:
  - Frame counter 0–15 → pix_colour 4'h7.
  - After 16 frame_start pulses → 4'h0.
  - After 32 pulses → 4'h7 again (wrap).
- Boundary strobes:
  - line_start with y=192: no memory activity, no fetch_done.
  - Second line_start during busy: ignored, single fetch_done.
  - rst_n pulsed at cycle 30 of a fetch: outputs at reset values, pix_valid 0 on subsequent pix_en.
- Overlap: fetch line 1 while continuously reading pixels of line 0. Every pixel matches line 0 data through the swap edge; line 1 data appears from the following lookup.
